// File: rtl/dec2bin_seq_if.sv
// Valid/ready bundle for the packed-BCD to binary converter.
// The source/consumer side uses master; the converter uses slave.
interface dec2bin_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic [4*DIGITS-1:0] bcd_in;
    logic                in_valid;
    logic                in_ready;
    logic [BIN_W-1:0]    bin_out;
    logic                err;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output bcd_in, in_valid, out_ready,
        input  in_ready, bin_out, err, out_valid
    );

    modport slave (
        input  bcd_in, in_valid, out_ready,
        output in_ready, bin_out, err, out_valid
    );
endinterface

// File: rtl/dec2bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// The result and the non-decimal-digit flag are returned over a valid/ready handshake.
module dec2bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic          clk,
    input  logic          reset,
    dec2bin_seq_if.slave  bus
);
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] shreg_q, shreg_d;
    logic [BIN_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                errf_q, errf_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                err_q, err_d;
    logic                ov_q, ov_d;
    logic                ir_q, ir_d;

    logic [3:0]          digit;
    logic [BIN_W+3:0]    acc_wide;
    logic [BIN_W-1:0]    acc_next;
    logic                errf_next;

    // acc*10 + digit as two shifts and an add, with headroom before truncation
    assign digit     = shreg_q[4*DIGITS-1 -: 4];
    assign acc_wide  = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                     + {{BIN_W{1'b0}}, digit};
    assign acc_next  = acc_wide[BIN_W-1:0];
    assign errf_next = errf_q | (digit > 4'd9);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        errf_d  = errf_q;
        bin_d   = bin_q;
        err_d   = err_q;
        ov_d    = ov_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                ir_d = 1'b1;
                if (ir_q && bus.in_valid) begin
                    shreg_d = bus.bcd_in;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(DIGITS - 1);
                    errf_d  = 1'b0;
                    ir_d    = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d   = acc_next;
                errf_d  = errf_next;
                shreg_d = shreg_q << 4;
                if (cnt_q == '0) begin
                    bin_d   = errf_next ? '0 : acc_next;
                    err_d   = errf_next;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // Returning to IDLE re-arms in_ready; the accept can only happen one edge later
                if (bus.out_ready) begin
                    ov_d    = 1'b0;
                    ir_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            errf_q  <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            ir_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            errf_q  <= errf_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.in_ready  = ir_q;
    assign bus.bin_out   = bin_q;
    assign bus.err       = err_q;
    assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_dec2bin_seq.sv
// Scoreboard bench for dec2bin_seq: expected results are queued at each accept
// and compared at each output handshake, with directed checks around them.
module tb_dec2bin_seq;
    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dec2bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    dec2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic             err;
        logic [BIN_W-1:0] bin;
    } exp_t;

    exp_t sbq[$];
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   n_out   = 0;
    logic ov_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, expv, expv, cyc);
        end
    endtask

    function automatic exp_t model(input logic [4*DIGITS-1:0] b);
        exp_t       r;
        int         v;
        logic       bad;
        logic [3:0] d;
        v   = 0;
        bad = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = b[4*i +: 4];
            if (d > 4'd9) bad = 1'b1;
            v = v * 10 + int'(d);
        end
        r.err = bad;
        r.bin = bad ? '0 : BIN_W'(v);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: push on accept, check latency on out_valid rise, pop on output handshake
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.in_valid && bus.in_ready) begin
                sbq.push_back(model(bus.bcd_in));
                acc_cyc = cyc + 1;
            end
            if (bus.out_valid && !ov_prev)
                chk("latency", cyc - acc_cyc, DIGITS);
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_bin", 32'(bus.bin_out), 32'(e.bin));
                    chk("sb_err", 32'(bus.err), 32'(e.err));
                end
                n_out++;
            end
        end
        ov_prev = bus.out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4*DIGITS-1:0] v, input bit hold);
        bit took;
        took = 1'b0;
        tick();
        bus.bcd_in   = v;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 60 && !took; i++) begin
            @(negedge clk);
            took = bus.in_ready;
            tick();
        end
        if (!took) chk("accept_timeout", 0, 1);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_ov();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        if (!seen) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
    endtask

    task automatic conv_direct(input string tag, input logic [4*DIGITS-1:0] v,
                               input int bin_exp, input bit err_exp);
        send(v, 1'b0);
        wait_ov();
        chk({tag, "_bin"}, 32'(bus.bin_out), bin_exp);
        chk({tag, "_err"}, 32'(bus.err), 32'(err_exp));
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int              n0;
        logic [15:0]     v;
        bus.bcd_in    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values and first-edge in_ready
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_bin", 32'(bus.bin_out), 0);
        chk("rst_err", 32'(bus.err), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rel_in_ready", 32'(bus.in_ready), 0);
        tick();
        chk("first_in_ready", 32'(bus.in_ready), 1);

        // Basic conversions
        bus.out_ready = 1'b1;
        conv_direct("t1234", 16'h1234, 1234, 1'b0);
        conv_direct("t9999", 16'h9999, 9999, 1'b0);
        conv_direct("t0000", 16'h0000, 0, 1'b0);
        conv_direct("t12A4", 16'h12A4, 0, 1'b1);
        conv_direct("t0042", 16'h0042, 42, 1'b0);
        conv_direct("tA000", 16'hA000, 0, 1'b1);

        // Backpressure: result held, in_ready low, new in_valid ignored
        bus.out_ready = 1'b0;
        send(16'h0777, 1'b0);
        wait_ov();
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.bcd_in   = 16'h0888;
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk("bp_bin", 32'(bus.bin_out), 777);
            chk("bp_ov", 32'(bus.out_valid), 1);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
        end
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ov_before", 32'(bus.out_valid), 1);
        tick();
        chk("bp_ov_fall", 32'(bus.out_valid), 0);
        chk("bp_in_ready_rise", 32'(bus.in_ready), 1);
        drain();
        chk("bp_no_extra", sbq.size(), 0);

        // Reset two clocks into a conversion
        send(16'h1234, 1'b0);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 0);
        chk("arst_ov", 32'(bus.out_valid), 0);
        chk("arst_bin", 32'(bus.bin_out), 0);
        chk("arst_err", 32'(bus.err), 0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("arst_rel_in_ready", 32'(bus.in_ready), 0);
        conv_direct("t0507", 16'h0507, 507, 1'b0);

        // Back-to-back with in_valid held high
        n0 = n_out;
        for (int i = 1; i <= 10; i++) begin
            v = 16'(((i / 10) << 4) | (i % 10));
            send(v, 1'b1);
        end
        bus.in_valid = 1'b0;
        drain();
        chk("b2b_count", n_out - n0, 10);

        repeat (4) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
